// File: rtl/exe_mdu.sv
// exe_mdu: iterative 32x32 multiply / divide unit beside the EXE-stage ALU.
// Runs a 32-step shift-add multiply or restoring divide, stalls the pipeline
// while running, then writes HI/LO and pulses done for one cycle. Also takes
// direct HI/LO writes (MTHI/MTLO) while idle.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous active-high reset
//   start   in   1  begin an operation (sampled in IDLE only)
//   op      in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a       in  32  multiplicand / dividend
//   b       in  32  multiplier / divisor
//   cancel  in   1  abort an operation in CALC or FIX
//   hi_we   in   1  write wdata to HI when not busy
//   lo_we   in   1  write wdata to LO when not busy
//   wdata   in  32  HI/LO write data
//   busy    out  1  operation in progress (CALC or FIX)
//   stall   out  1  combinational pipeline hold
//   done    out  1  one-cycle completion pulse
//   hi      out 32  HI register
//   lo      out 32  LO register
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; HI/LO writable
// CALC  | one multiply/divide step per cycle, counter 0..31
// FIX   | sign correction and special cases, HI/LO written
// DONE  | done pulse; pipeline released
module exe_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  // acc: multiply -> {partial product high, remaining multiplier bits}
  //      divide   -> {partial remainder, dividend/quotient bits}
  logic [63:0] acc;
  logic [63:0] acc_step;
  logic [31:0] mag_b;
  logic [31:0] a_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rem_neg_q;

  logic        op_signed;
  logic        sign_a, sign_b;
  logic [31:0] mag_a_in, mag_b_in;

  logic [32:0] mul_upper;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;

  logic [63:0] prod_neg;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] res_hi, res_lo;

  // Signed ops are the ones with op[0]=0 (MULT, DIV).
  assign op_signed = ~op[0];
  assign sign_a    = op_signed & a[31];
  assign sign_b    = op_signed & b[31];
  assign mag_a_in  = sign_a ? (~a + 32'd1) : a;
  assign mag_b_in  = sign_b ? (~b + 32'd1) : b;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cancel)             state_nxt = S_IDLE;
        else if (cnt == 5'd31)  state_nxt = S_FIX;
      end
      S_FIX: begin
        busy = 1'b1;
        if (cancel) state_nxt = S_IDLE;
        else        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gated by rst so a start held during reset does not hold the pipeline.
  assign stall = ~rst & (busy | (start & (state == S_IDLE)));

  // One iteration of the datapath.
  always_comb begin
    mul_upper = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    rem_sh    = {acc[63:32], acc[31]};
    rem_ge    = rem_sh >= {1'b0, mag_b};
    // True difference is below 2^32 whenever rem_ge holds.
    rem_sub   = rem_sh[31:0] - mag_b;
    acc_step  = acc;
    if (is_div_q) begin
      if (rem_ge) acc_step = {rem_sub,       acc[30:0], 1'b1};
      else        acc_step = {rem_sh[31:0],  acc[30:0], 1'b0};
    end else begin
      acc_step = {mul_upper, acc[31:1]};
    end
  end

  // Final result selection.
  always_comb begin
    prod_neg = ~acc + 64'd1;
    quo_fix  = neg_q     ? (~acc[31:0]  + 32'd1) : acc[31:0];
    rem_fix  = rem_neg_q ? (~acc[63:32] + 32'd1) : acc[63:32];
    if (!is_div_q) begin
      res_hi = neg_q ? prod_neg[63:32] : acc[63:32];
      res_lo = neg_q ? prod_neg[31:0]  : acc[31:0];
    end else if (mag_b == 32'd0) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      acc       <= 64'd0;
      mag_b     <= 32'd0;
      a_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt       <= 5'd0;
            acc       <= {32'd0, mag_a_in};
            mag_b     <= mag_b_in;
            a_q       <= a;
            is_div_q  <= op[1];
            neg_q     <= sign_a ^ sign_b;
            rem_neg_q <= sign_a;
          end
        end
        S_CALC: begin
          if (!cancel) begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
          end
        end
        default: ;
      endcase

      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end

      if ((state == S_FIX) && !cancel) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
module tb_exe_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  exe_mdu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
        chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one operation and follow it to its done pulse. disturb_at>0 injects
  // a start and hi_we pulse while busy, at that many cycles after start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int disturb_at);
    int          stall_cnt;
    bit          got;
    logic [31:0] hi_before;
    @(posedge clk); #1;
    hi_before = hi;
    start = 1'b1; op = o; a = va; b = vb;
    exp_q.push_back('{exp_hi, exp_lo, cyc + 34});
    stall_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1)       got = 1'b1;
      else if (stall === 1'b1) stall_cnt++;
      if (i == 1) start = 1'b0;
      if (disturb_at > 0 && i == disturb_at + 1) begin
        start = 1'b0;
        hi_we = 1'b0;
        chk("hi_we_while_busy", {32'd0, hi}, {32'd0, hi_before});
      end
      if (disturb_at > 0 && i == disturb_at) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("stall_cycles", 64'(stall_cnt), 64'd34);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst = 1'b1; start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;

    // Reset held with start asserted.
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi",    {32'd0, hi}, 64'd0);
    chk("rst_lo",    {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);

    // Directed operations.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op(2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0);

    // Direct HI write while idle.
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    hi_we = 1'b0;
    @(negedge clk);
    chk("mthi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});

    // LO preload, then a DIVU cancelled at step 10.
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    @(negedge clk);
    chk("mtlo", {32'd0, lo}, {32'd0, 32'h1234_5678});
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_cancel", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_lo", {32'd0, lo}, {32'd0, 32'h1234_5678});
    chk("cancel_hi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("cancel_no_done", 64'(done_cnt), 64'(dc));

    // MULTU with start and hi_we pulsed mid-operation.
    run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 5);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mdu.md
# exe_mdu

Iterative multiply/divide unit with its own sequencing controller, sitting beside the EXE-stage ALU. It accepts MULT/MULTU/DIV/DIVU operands from the EXE stage and runs a 32-step shift-add or restoring-divide loop. While it runs, it stalls the pipeline. When finished, it writes the HI/LO result registers and reports completion with a one-cycle done pulse. It also services direct HI/LO writes (MTHI/MTLO).

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation code, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  multiplicand or dividend (rs value).
- b  in  32  multiplier or divisor (rt value).
- cancel  in  1  abort the operation in progress (exception/flush).
- hi_we  in  1  write wdata to HI; honoured only when busy=0.
- lo_we  in  1  write wdata to LO; honoured only when busy=0.
- wdata  in  32  data for hi_we/lo_we.
- busy  out  1  an operation is in progress (CALC or FIX state).
- stall  out  1  combinational pipeline hold request.
- done  out  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- hi  out  32  HI register (high product word, or remainder).
- lo  out  32  LO register (low product word, or quotient).

## Operation
- State machine with states IDLE, CALC, FIX, DONE.
  - IDLE: if start=1, latch op, a and b, compute operand magnitudes and result signs, clear the step counter, and go to CALC.
  - CALC: 32 iterations, one per cycle, with a 5-bit counter running 0..31. Exit to FIX after the step where counter=31.
  - FIX: apply sign correction and the special cases, write hi/lo, then go to DONE.
  - DONE: done=1 for this cycle only, then go to IDLE.
- Signed ops (MULT, DIV) iterate on magnitudes |a| and |b|.
  - Product is negated when sign(a)≠sign(b).
  - Quotient is negated when sign(a)≠sign(b).
  - Remainder takes the sign of a.
- Unsigned ops use the operands as given.
- Multiply: a 64-bit accumulator using shift-add, 1 multiplier bit per step. hi gets product[63:32], lo gets product[31:0].
- Divide: restoring division, one quotient bit per step, with a 33-bit partial remainder. lo gets the quotient, hi gets the remainder.
- Divide by zero (b=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a unmodified. Latency is the same as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This result falls out of the magnitude arithmetic.
- busy=1 in CALC and FIX.
- stall = busy | (start & IDLE). DONE does not stall, so the instruction advances in the done cycle.
- start while busy=1 or in DONE is ignored.
- hi_we/lo_we while busy=1 are ignored.
- hi_we/lo_we together with start in IDLE: the write takes effect. The operation's result later overwrites HI/LO at FIX.
- cancel in CALC or FIX: go to IDLE at the next edge, hi/lo unchanged, no done pulse.
- cancel in IDLE or DONE has no effect.
- cancel has priority over the FIX write in the same cycle.

## Timing
- Reset (rst=1 at an edge): state=IDLE, counter=0, busy=0, done=0, stall=0, hi=0, lo=0, internal accumulators=0.
- rst overrides start, cancel and the write enables.
- Let edge E0 be the edge that accepts start.
  - CALC steps happen on edges E1..E32.
  - FIX writes hi/lo on edge E33.
  - done=1 in the cycle between E33 and E34.
  - State is IDLE again after E34.
- Result latency is 34 cycles from E0. stall is high for 34 cycles, from the start cycle through the cycle before done.
- A new start is accepted on edge E35 at the earliest. The start may be presented during the done cycle but is not sampled until IDLE.
- A HI/LO write lands at the next edge and is visible on hi/lo one cycle after hi_we/lo_we.

## Test plan
- Reset: assert rst for 2 cycles with start=1 → busy=0, done=0, stall=0, hi=lo=0, no operation begins.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → stall for 34 cycles; done pulses once, at 34 cycles after acceptance; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21). Then MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload via lo_we=1 with wdata=0x12345678, then DIVU 100/7 with cancel at CALC step 10 → busy drops next edge, no done, lo still 0x12345678.
- During a running MULTU 3×5: pulse start with different operands and pulse hi_we=1 with wdata=0xDEADBEEF → both ignored; final hi=0, lo=15.
